div_iter_unit: RTL and testbench

- Multi-cycle 32-bit integer divider. It is the responder side of the EX-stage divide handshake (start/ready/annul).
- EX drives operands and holds start_i high while it stalls the pipeline. This block iterates one quotient bit per clock, then asserts ready_o with {remainder, quotient} until EX releases start_i.
- The result feeds the HI (remainder) and LO (quotient) write path.

---
 rtl/div_iter_unit.sv | 167 ++++++++++++++++
 tb/tb_div_iter_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Multi-cycle 32-bit restoring divider for the EX-stage divide handshake.
// One quotient bit is resolved per clock. {remainder, quotient} is held on result_o while ready_o is high.
module div_iter_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        ON       = 2'd2,
        END      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  counter;
    logic [31:0] dividend_sh;
    logic [31:0] divisor_mag;
    logic [31:0] rem;
    logic [31:0] quot;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        abort_on;
    logic        last_iter;
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;

    logic [32:0] partial;
    logic        take;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] rem_fix;
    logic [31:0] quot_fix;

    assign accept    = start_i && !annul_i;
    assign abort_on  = annul_i || !start_i;
    assign last_iter = (counter == 5'd31);

    // Magnitudes use 32-bit wrap, so 0x80000000 maps onto itself and divides correctly as unsigned.
    assign op1_neg = signed_div_i && opdata1_i[31];
    assign op2_neg = signed_div_i && opdata2_i[31];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        partial   = {rem, dividend_sh[31]};
        take      = (partial >= {1'b0, divisor_mag});
        rem_step  = partial[31:0];
        if (take) begin
            rem_step = partial[31:0] - divisor_mag;
        end
        quot_step = {quot[30:0], take};
        rem_fix   = neg_r ? -rem_step : rem_step;
        quot_fix  = neg_q ? -quot_step : quot_step;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == 32'd0) ? DIV_ZERO : ON;
                end
            end
            DIV_ZERO: state_nxt = END;
            ON: begin
                if (abort_on) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter     <= 5'd0;
            dividend_sh <= 32'd0;
            divisor_mag <= 32'd0;
            rem         <= 32'd0;
            quot        <= 32'd0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_o    <= 64'd0;
            ready_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        dividend_sh <= op1_mag;
                        divisor_mag <= op2_mag;
                        neg_q       <= op1_neg ^ op2_neg;
                        neg_r       <= op1_neg;
                        rem         <= 32'd0;
                        quot        <= 32'd0;
                        counter     <= 5'd0;
                    end
                end
                DIV_ZERO: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
                ON: begin
                    if (abort_on) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else begin
                        rem         <= rem_step;
                        quot        <= quot_step;
                        dividend_sh <= {dividend_sh[30:0], 1'b0};
                        counter     <= counter + 5'd1;
                        if (last_iter) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    // A divide-by-zero reaches END with ready low, so ready rises two edges after acceptance.
                    if (!start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else begin
                        ready_o  <= 1'b1;
                    end
                end
                default: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed table, handshake corner sequences,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    div_iter_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division, remainder takes the dividend's sign; x/0 gives 0.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    task automatic wait_ready(input bit scramble, output int lat);
        lat = 0;
        while (!ready_o && lat < 60) begin
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
            tick();
            lat++;
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            tick();
            seen = seen | ready_o | (|result_o);
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic run_op(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input bit scramble);
        int lat;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        wait_ready(scramble, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result_o, exp);
        annul_i = 1'b1;
        repeat (2) tick();
        annul_i = 1'b0;
        check({name, " hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        start_i = 1'b0;
        tick();
        check({name, " release ready"}, 64'(ready_o), 64'd0);
        check({name, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;

        vecs[0] = '{"divu 100/7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32};
        vecs[1] = '{"div -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 32};
        vecs[2] = '{"div 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 32};
        vecs[3] = '{"div 1234/0",     1'b1, 32'd1234,       32'd0,          64'h00000000_00000000, 2};
        vecs[4] = '{"div overflow",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 32};
        vecs[5] = '{"divu max/1",     1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 32};
        vecs[6] = '{"divu 5/10",      1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 32};
        vecs[7] = '{"divu max/max",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 32};
        vecs[8] = '{"div -9/-4",      1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFC,  64'hFFFFFFFF_00000002, 32};
        vecs[9] = '{"divu 0/0",       1'b0, 32'd0,          32'd0,          64'h00000000_00000000, 2};

        resetn       = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (2) tick();
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        #2 resetn = 1'b1;
        idle_check("idle after reset", 3);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);
        end

        // Annul at iteration 10 with start dropped alongside: nothing is ever reported.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (9) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        idle_check("annul no ready", 40);
        run_op("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 1'b0);

        // Annul pulse with start held: the op restarts from IDLE with the operands present then.
        opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (9) tick();
        annul_i = 1'b1;
        opdata1_i = 32'd9; opdata2_i = 32'd3;
        tick();
        annul_i = 1'b0;
        wait_ready(1'b0, lat);
        check("annul restart latency", 64'(lat), 64'd33);
        check("annul restart result", result_o, 64'h00000000_00000003);
        start_i = 1'b0;
        tick();

        // start with annul in IDLE is not accepted.
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) tick();
        annul_i = 1'b0;
        tick();
        wait_ready(1'b0, lat);
        check("start+annul latency", 64'(lat), 64'd32);
        check("start+annul result", result_o, 64'hFFFFFFFE_FFFFFFF2);
        start_i = 1'b0;
        tick();

        // Reset at iteration 20, then released with start low.
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        repeat (19) tick();
        #2 resetn = 1'b0;
        #1;
        check("reset mid-op ready", 64'(ready_o), 64'd0);
        check("reset mid-op result", result_o, 64'd0);
        start_i = 1'b0;
        tick();
        #2 resetn = 1'b1;
        idle_check("no stale ready after reset", 40);

        // Reset while a result is held: outputs clear without waiting for a clock edge.
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        wait_ready(1'b0, lat);
        check("pre-reset result", result_o, 64'h00000002_0000000F);
        #2 resetn = 1'b0;
        #1;
        check("async reset ready", 64'(ready_o), 64'd0);
        check("async reset result", result_o, 64'd0);
        start_i = 1'b0;
        tick();
        #2 resetn = 1'b1;
        idle_check("idle after async reset", 5);

        // Random operations; operands are scrambled after acceptance and must not matter.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op($sformatf("rand %0d", i), sgn, a, b, model(sgn, a, b), (b == 32'd0) ? 2 : 32, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
